// File: rtl/key_pattern_pkg.sv
// Shared constants and the LED pattern ROM for the key-driven pattern controller.
package key_pattern_pkg;

  localparam int KEY_UP   = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_SEL  = 2;
  localparam int KEY_AUTO = 3;

  localparam logic FIELD_PAT   = 1'b0;
  localparam logic FIELD_SPEED = 1'b1;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  localparam int ROM_W = 16;

  // Index 0 is all off; indices at or beyond num_patterns are dark as well.
  function automatic logic [ROM_W-1:0] pattern_rom(input int unsigned idx,
                                                   input int unsigned num_patterns);
    logic [ROM_W-1:0] word;
    word = '0;
    if (idx < num_patterns) begin
      case (idx)
        0:  word = 16'h0000;
        1:  word = 16'h0001;
        2:  word = 16'h0002;
        3:  word = 16'h0004;
        4:  word = 16'h0008;
        5:  word = 16'h0003;
        6:  word = 16'h000C;
        7:  word = 16'h000F;
        8:  word = 16'h0005;
        9:  word = 16'h000A;
        10: word = 16'h0006;
        11: word = 16'h0009;
        12: word = 16'h0007;
        13: word = 16'h000E;
        14: word = 16'h000B;
        15: word = 16'h000D;
        default: word = '0;
      endcase
    end
    return word;
  endfunction

endpackage

// File: rtl/key_pattern_ctrl_auto_timer.sv
// Millisecond prescaler plus period counter; pulses expire when the
// speed-scaled auto-advance period has elapsed.
module auto_timer #(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int AUTO_PERIOD_MS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       restart,
  input  logic [1:0] speed,
  output logic       expire
);

  localparam int PRE_CNT = CLK_FREQ_HZ / 1000;
  localparam int PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
  localparam int MS_MAX  = AUTO_PERIOD_MS * 4;
  localparam int MS_W    = $clog2(MS_MAX + 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [MS_W-1:0]  ms_cnt;
  logic [MS_W-1:0]  period_ms;
  logic             ms_tick;

  assign ms_tick   = (pre_cnt == PRE_W'(PRE_CNT - 1));
  assign period_ms = MS_W'(AUTO_PERIOD_MS * (int'(speed) + 1));
  assign expire    = enable && ms_tick && (ms_cnt == period_ms - MS_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (!enable || restart) begin
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else if (ms_tick) begin
      pre_cnt <= '0;
      ms_cnt  <= expire ? '0 : ms_cnt + MS_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/key_pattern_ctrl.sv
// Turns key event pulses into pattern/speed/auto control state and drives
// the registered LED pattern word.
module key_pattern_ctrl
  import key_pattern_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 50000000,
  parameter int AUTO_PERIOD_MS = 500,
  parameter int NUM_PATTERNS   = 8,
  parameter int PAT_W          = 4,
  parameter int LED_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key_pulse,
  output logic [PAT_W-1:0] pat_idx,
  output logic [1:0]       speed,
  output logic             auto_en,
  output logic             sel_field,
  output logic             adv_pulse,
  output logic [LED_W-1:0] led_out
);

  if (NUM_PATTERNS < 2 || NUM_PATTERNS > 16 || (2 ** PAT_W) < NUM_PATTERNS) begin : g_param_check
    $error("key_pattern_ctrl: NUM_PATTERNS/PAT_W out of range");
  end

  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

  logic [PAT_W-1:0] pat_nxt, pat_inc;
  logic [1:0]       speed_nxt;
  logic             auto_nxt, sel_nxt, adv_nxt;
  logic [LED_W-1:0] led_nxt;
  logic             up_evt, dn_evt, manual_pat, restart, expire;

  assign up_evt  = key_pulse[KEY_UP] && !key_pulse[KEY_DOWN];
  assign dn_evt  = key_pulse[KEY_DOWN] && !key_pulse[KEY_UP];
  assign pat_inc = (pat_idx == PAT_LAST) ? '0 : pat_idx + PAT_W'(1);

  auto_timer #(
    .CLK_FREQ_HZ   (CLK_FREQ_HZ),
    .AUTO_PERIOD_MS(AUTO_PERIOD_MS)
  ) u_auto_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (auto_en),
    .restart(restart),
    .speed  (speed),
    .expire (expire)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pat_nxt    = pat_idx;
    speed_nxt  = speed;
    adv_nxt    = 1'b0;
    manual_pat = 1'b0;
    restart    = 1'b0;

    // up/down act on the field held before the edge; sel is applied afterwards.
    if (sel_field == FIELD_PAT) begin
      if (up_evt) begin
        pat_nxt    = pat_inc;
        manual_pat = 1'b1;
      end else if (dn_evt) begin
        pat_nxt    = (pat_idx == '0) ? PAT_LAST : pat_idx - PAT_W'(1);
        manual_pat = 1'b1;
      end
    end else begin
      if (up_evt && speed != SPEED_MAX) begin
        speed_nxt = speed + 2'd1;
        restart   = 1'b1;
      end else if (dn_evt && speed != 2'd0) begin
        speed_nxt = speed - 2'd1;
        restart   = 1'b1;
      end
    end

    // A manual move overrides a coincident expiry, giving one step and one pulse.
    if (manual_pat) begin
      adv_nxt = 1'b1;
      restart = 1'b1;
    end else if (expire) begin
      pat_nxt = pat_inc;
      adv_nxt = 1'b1;
    end

    sel_nxt  = sel_field ^ key_pulse[KEY_SEL];
    auto_nxt = auto_en ^ key_pulse[KEY_AUTO];
    if (!auto_en && auto_nxt) restart = 1'b1;

    led_nxt = LED_W'(pattern_rom(32'(pat_nxt), 32'(NUM_PATTERNS)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_idx   <= '0;
      speed     <= '0;
      auto_en   <= 1'b0;
      sel_field <= FIELD_PAT;
      adv_pulse <= 1'b0;
      led_out   <= LED_W'(pattern_rom(0, 32'(NUM_PATTERNS)));
    end else begin
      pat_idx   <= pat_nxt;
      speed     <= speed_nxt;
      auto_en   <= auto_nxt;
      sel_field <= sel_nxt;
      adv_pulse <= adv_nxt;
      led_out   <= led_nxt;
    end
  end

endmodule
